// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and default width.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_unit.sv
// Sequential shift-add multiplier holding the architectural HI/LO product registers.
//
// Handshake: start is sampled only while the unit is idle (IDLE or DONE).
// Once accepted, busy is high for exactly WIDTH cycles and start is ignored.
// done then pulses for one cycle, and hi/lo hold the new product from that
// cycle on. busy and done are never high together. Holding start during the
// done cycle launches the next multiply with no idle cycle in between.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] acc;      // one spare bit above the product catches the add carry
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_next;
    logic [2*WIDTH-1:0] product;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // One shift-add step and the sign-corrected product it would yield on the final step.
    always_comb begin
        upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
        if (mplier[0]) begin
            acc_next = {upper_sum, acc[WIDTH-1:0]} >> 1;
        end else begin
            acc_next = acc >> 1;
        end
        product = neg ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
    end

    // Control FSM plus datapath registers; hi/lo only move on the final BUSY step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        state  <= BUSY;
                    end else begin
                        state  <= IDLE;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= product[2*WIDTH-1:WIDTH];
                        lo    <= product[WIDTH-1:0];
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags are plain decodes of the registered state.
    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: arithmetic reference model with a
// per-cycle compare, plus directed vectors with literal expectations.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int failures = 0;

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Reference model: an accepted request yields its full product
    // exactly W cycles later; hi/lo show the last finished product.
    // ---------------------------------------------------------------
    logic [2*W-1:0] exp_q[$];
    int             m_left = 0;
    logic           m_done = 1'b0;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x,
                                                   input logic [W-1:0] y,
                                                   input logic sgn);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        if (sgn) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
        end else begin
            sx = {{W{1'b0}}, x};
            sy = {{W{1'b0}}, y};
        end
        return sx * sy;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [2*W-1:0] p;
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                p      = exp_q.pop_front();
                m_hi   = p[2*W-1:W];
                m_lo   = p[W-1:0];
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                exp_q.push_back(ref_product(a, b, is_signed));
                m_left = W;
            end
        end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        checks++;
        if ({busy, done, hi, lo} !== {(m_left > 0), m_done, m_hi, m_lo}) begin
            failures++;
            $display("FAIL cycle_compare t=%0t: actual busy=%b done=%b hi=%h lo=%h required busy=%b done=%b hi=%h lo=%h",
                     $time, busy, done, hi, lo, (m_left > 0), m_done, m_hi, m_lo);
        end
    end

    // ---------------------------------------------------------------
    // driver tasks
    // ---------------------------------------------------------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge: present a request for one cycle.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
        start     = 1'b1;
        a         = x;
        b         = y;
        is_signed = sgn;
        @(negedge clk);
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
    endtask

    // Count busy cycles up to the done pulse and check the literal result.
    task automatic wait_done(input string name, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, W'(cycles), W'(32));
        check({name, "_done"}, W'(done), W'(1));
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_mult(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sgn, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        @(negedge clk);
        start_op(x, y, sgn);
        wait_done(name, exp_hi, exp_lo);
    endtask

    // ---------------------------------------------------------------
    // directed sequence
    // ---------------------------------------------------------------
    initial begin
        int cycles;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        rst = 1'b0;

        // first start right after reset release
        start_op(32'd7, 32'd6, 1'b0);
        wait_done("u7x6", 32'h0000_0000, 32'h0000_002A);

        run_mult("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mult("sm3x5", 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_mult("s7xm1", 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        run_mult("u0xff", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0000);
        run_mult("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);

        // start during BUSY is ignored; hi/lo keep the old product until done
        @(negedge clk);
        start_op(32'h0000_1234, 32'h0000_0010, 1'b0);
        cycles = 1;
        while (busy === 1'b1 && cycles < 100) begin
            if (cycles == 10) begin
                start = 1'b1; a = 32'h0000_0003; b = 32'h0000_0003; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (cycles == 31) begin
                check("ignore_old_hi", hi, 32'h4000_0000);
                check("ignore_old_lo", lo, 32'h0000_0000);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("ignore_busy_cycles", W'(cycles - 1), W'(32));
        check("ignore_hi", hi, 32'h0000_0000);
        check("ignore_lo", lo, 32'h0001_2340);

        // reset in the middle of a multiply
        @(negedge clk);
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        repeat (14) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_mult("after_rst", 32'd9, 32'd9, 1'b0, 32'h0, 32'd81);

        // back-to-back: request held during the done cycle
        run_mult("b2b_first", 32'd100, 32'd100, 1'b0, 32'h0, 32'd10000);
        start_op(32'd2, 32'd3, 1'b0);
        check("b2b_no_idle", W'(busy), W'(1));
        wait_done("b2b_second", 32'h0, 32'd6);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
